uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter NREQ, default 4, meaning number of byte requesters; fixed at 4 in this revision.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester byte-ready flags; bit i belongs to requester i.
REQ-006 data_in  input  32  requester bytes; requester i uses data_in[8i+7:8i].
REQ-007 parity_mode  input  2  00 none, 01 even (bit = XOR of data), 10 odd (bit = XNOR of data), 11 none.
REQ-008 gnt  output  4  one-hot, one-cycle pulse marking the accepted requester.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 owner  output  2  index of the last granted requester.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE with req != 0, the block SHALL grant round-robin: first set bit searching upward from owner+1, wrapping 3->0.
REQ-014 The grant cycle SHALL pulse gnt, latch the selected byte, update owner, clear the baud counter and enter START on the next edge.
REQ-015 req SHALL be sampled only in IDLE; req changes during a frame have no effect on that frame.
REQ-016 Each bit state SHALL last exactly CLKS_PER_BIT cycles, timed by a 16-bit counter that wraps to 0 at CLKS_PER_BIT-1.
REQ-017 tx SHALL be 0 in START, latched bit n (LSB first, n=0..7) in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-018 Transitions: START->DATA after 1 bit; DATA->PARITY (or ->STOP when parity is off) after bit 7; PARITY->STOP; STOP->IDLE.
REQ-019 parity_mode SHALL be sampled in the grant cycle and held for the whole frame.
REQ-020 Consecutive frames SHALL be separated by exactly one IDLE clk cycle (tx=1).
REQ-021 A requester that holds req high SHALL NOT be granted twice in a row while any other req bit is set.
REQ-022 If req is 0 in IDLE, no gnt SHALL pulse and tx SHALL stay 1.

Reset
REQ-023 On reset assertion, regardless of the current state, the block SHALL immediately force state=IDLE, tx=1, gnt=0, busy=0, owner=3, counters=0 and the data latch=0.
REQ-024 After reset deassertion, the first grant SHALL go to the lowest-indexed requesting bit, because owner=3.

Configuration
REQ-025 Macro UART_TX_SCHED_PARITY_EN defined: the PARITY state exists and is entered when the latched parity_mode is 01 or 10; frames are 11 bits.
REQ-026 UART_TX_SCHED_PARITY_EN undefined: the PARITY state and parity logic are omitted, parity_mode is ignored, and every frame is 10 bits.

Verification
REQ-027 Reset, then req=0001, data byte0=0xA5, mode=00, CLKS_PER_BIT=4 -> gnt=0001 for 1 cycle; tx=0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles; busy high for 40 cycles.
REQ-028 PARITY_EN defined, byte 0x07, mode=01 -> parity bit 1; mode=10 -> parity bit 0; mode=11 -> no parity bit, 10-bit frame.
REQ-029 req=1111 held high -> grants 0001, 0010, 0100, 1000, 0001 with exactly 1 idle cycle between frames.
REQ-030 owner=1, req=0101 -> next grant 0100, following grant 0001.
REQ-031 Reset asserted mid-DATA -> tx=1 and busy=0 in the same cycle; after release with req=1000, gnt=1000.
REQ-032 req toggled and data_in changed during a frame -> transmitted bits match the byte latched at grant, and no extra gnt pulses occur.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmitter: grants one of four byte requesters and serialises its byte LSB-first.
// Build option: define UART_TX_SCHED_PARITY_EN to add the optional parity bit (even/odd chosen per frame).
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NREQ         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [31:0]     data_in,
    input  logic [1:0]      parity_mode,
    output logic [NREQ-1:0] gnt,
    output logic            tx,
    output logic            busy,
    output logic [1:0]      owner
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_SCHED_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [1:0]  sel;
    logic        bit_done;

`ifdef UART_TX_SCHED_PARITY_EN
    logic [1:0]  pmode;
    logic        par_on;
    logic        par_bit;

    assign par_on  = (pmode == 2'b01) || (pmode == 2'b10);
    assign par_bit = (pmode == 2'b01) ? ^shreg : ~^shreg;
`else
    logic        unused_parity;

    assign unused_parity = ^parity_mode;
`endif

    assign bit_done = (cnt == LAST);

    // First requester found searching upward from the one after the last owner.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        cand  = '0;
        found = 1'b0;
        sel   = owner;
        for (int i = 1; i <= 4; i++) begin
            cand = owner + 2'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            gnt     <= '0;
            busy    <= 1'b0;
            owner   <= 2'd3;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
            pmode   <= '0;
`endif
        end else begin
            gnt <= '0;
            if (state != IDLE)
                cnt <= bit_done ? 16'd0 : cnt + 16'd1;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (req != '0) begin
                        gnt     <= NREQ'(1) << sel;
                        owner   <= sel;
                        shreg   <= data_in[{sel, 3'b000} +: 8];
`ifdef UART_TX_SCHED_PARITY_EN
                        pmode   <= parity_mode;
`endif
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                            if (par_on) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboarded bench for uart_tx_sched: frame-level reference model feeds a queue, monitor checks the serial line.
module tb_uart_tx_sched;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  parity_mode = '0;
    logic [3:0]  gnt;
    logic        tx;
    logic        busy;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .NREQ(4)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .parity_mode(parity_mode), .gnt(gnt), .tx(tx), .busy(busy), .owner(owner)
    );

    typedef struct {
        logic [3:0] g;
        int         own;
        logic [7:0] b;
        logic [1:0] pm;
        int         at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   m_owner = 3;
    int   m_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit has_parity(input logic [1:0] pm);
`ifdef UART_TX_SCHED_PARITY_EN
        return (pm == 2'b01) || (pm == 2'b10);
`else
        return (pm == 2'b10) && 1'b0;
`endif
    endfunction

    function automatic int frame_len(input logic [1:0] pm);
        return has_parity(pm) ? 11 : 10;
    endfunction

    // Serial line value for bit position k of a frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input logic [1:0] pm, input int k);
        int ones;
        ones = $countones(b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && has_parity(pm))
            return (pm == 2'b01) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return 1'b1;
    endfunction

    // Drive one cycle of inputs and advance the frame-level model.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic [1:0] pm);
        int   w;
        exp_t e;
        @(negedge clk);
        req = r;
        data_in = d;
        parity_mode = pm;
        if (m_wait > 0) begin
            m_wait--;
        end else if (r != 0) begin
            w = m_owner;
            for (int i = 1; i <= 4; i++) begin
                w = (m_owner + i) % 4;
                if (r[w]) break;
            end
            e.g   = 4'b0001 << w;
            e.own = w;
            e.b   = d[8*w +: 8];
            e.pm  = pm;
            e.at  = cyc + 1;
            sbq.push_back(e);
            m_owner = w;
            m_wait  = frame_len(pm) * CPB;
        end
    endtask

    task automatic check_frame(input exp_t e);
        int len;
        len = frame_len(e.pm);
        chk("gnt_value", gnt, e.g);
        chk("owner_at_gnt", owner, e.own);
        chk("gnt_cycle", cyc, e.at);
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k != 0 || c != 0) begin
                    @(negedge clk);
                    chk("gnt_single_pulse", gnt, 4'b0000);
                end
                chk($sformatf("tx_bit%0d", k), tx, line_bit(e.b, e.pm, k));
                chk("busy_in_frame", busy, 1'b1);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (gnt != 4'b0000) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_gnt: got %b expected none (cycle %0d)", gnt, cyc);
                    end else begin
                        e = sbq.pop_front();
                        check_frame(e);
                    end
                end else begin
                    chk("idle_tx", tx, 1'b1);
                    chk("idle_busy", busy, 1'b0);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 2'd3);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single 0xA5 frame from requester 0, no parity.
        step(4'b0001, 32'h0000_00A5, 2'b00);
        repeat (50) step(4'b0000, $urandom, 2'b00);

        // Move owner to 1, then 0101 must go 2 then 0.
        step(4'b0010, $urandom, 2'b00);
        repeat (45) step(4'b0000, $urandom, 2'b00);
        repeat (100) step(4'b0101, $urandom, 2'b00);
        repeat (50) step(4'b0000, $urandom, 2'b00);

        // All requesters held high: strict rotation, one idle cycle apart.
        repeat (5 * (10 * CPB + 1) + 2) step(4'b1111, $urandom, 2'b00);
        repeat (50) step(4'b0000, $urandom, 2'b00);

        // Parity modes on byte 0x07.
        for (int pm = 1; pm <= 3; pm++) begin
            step(4'b0001 << (m_owner == 3 ? 0 : (m_owner + 1) % 4), 32'h0707_0707, 2'(pm));
            repeat (50) step(4'b0000, $urandom, 2'(pm));
        end

        // Random traffic; req and data keep changing mid-frame.
        repeat (3000) begin
            logic [3:0] r;
            r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            step(r, $urandom, 2'($urandom_range(0, 3)));
        end
        repeat (60) step(4'b0000, $urandom, 2'b00);
        chk("scoreboard_drained", sbq.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of the data bits.
        step(4'b0001, 32'h0000_00FF, 2'b00);
        repeat (4 * CPB) step(4'b0000, $urandom, 2'b00);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_tx", tx, 1'b1);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_gnt", gnt, 4'b0000);
        chk("midreset_owner", owner, 2'd3);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        chk("post_reset_gnt", gnt, 4'b1000);
        chk("post_reset_owner", owner, 2'd3);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
